fifo_burst_reader: RTL and testbench

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

---
 rtl/fifo_burst_reader.sv | 141 ++++++++++++++
 tb/tb_fifo_burst_reader.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_reader.sv
// Burst reader: drains a show-ahead FIFO into a request/write-beat/response
// bus, splitting a transfer into bursts of at most BURST_LEN beats.
module fifo_burst_reader #(
  parameter int DATA_BITS = 32,
  parameter int BURST_LEN = 4,
  parameter int CNT_BITS  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [31:0]          base_addr_i,
  input  logic [15:0]          total_beats_i,
  input  logic [CNT_BITS-1:0]  fifo_cnt_i,
  input  logic [DATA_BITS-1:0] fifo_data_i,
  output logic                 fifo_ren_o,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output logic [31:0]          req_addr_o,
  output logic [3:0]           req_len_o,
  output logic                 wvalid_o,
  input  logic                 wready_i,
  output logic [DATA_BITS-1:0] wdata_o,
  output logic                 wlast_o,
  input  logic                 resp_valid_i,
  input  logic                 resp_err_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int BYTES = DATA_BITS / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_DATA, S_REQ, S_DATA, S_RESP, S_FIN
  } state_e;

  state_e      state_q;
  logic [31:0] addr_q;
  logic [15:0] rem_q;
  logic [4:0]  blen_q;   // beats in the current burst, 1..16
  logic [4:0]  beat_q;   // beats accepted so far in the current burst
  logic        err_q;

  logic [15:0] rem_d;
  logic [31:0] addr_d;
  logic        last_beat;
  logic        fifo_ready;

  // Burst size is the smaller of the configured maximum and what is left.
  function automatic logic [4:0] burst_of(input logic [15:0] rem);
    if (rem >= 16'(BURST_LEN)) return 5'(BURST_LEN);
    else                       return rem[4:0];
  endfunction

  // Post-burst address/remaining values, applied when the response arrives.
  always_comb begin
    rem_d      = rem_q - 16'(blen_q);
    addr_d     = addr_q + (32'(blen_q) * 32'(BYTES));
    last_beat  = (beat_q == (blen_q - 5'd1));
    fifo_ready = (32'(fifo_cnt_i) >= 32'(blen_q));
  end

  // Transfer sequencer: all counters and the sticky error live here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      blen_q  <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            // Any accepted start begins a fresh transfer, so the old error goes.
            err_q <= 1'b0;
            if (total_beats_i != 16'd0) begin
              addr_q  <= base_addr_i;
              rem_q   <= total_beats_i;
              blen_q  <= burst_of(total_beats_i);
              beat_q  <= '0;
              state_q <= S_WAIT_DATA;
            end else begin
              state_q <= S_FIN;
            end
          end
        end
        S_WAIT_DATA: begin
          // Only request once the whole burst is already in the FIFO, so the
          // data phase never has to stall on an empty FIFO.
          beat_q <= '0;
          if (fifo_ready) state_q <= S_REQ;
        end
        S_REQ: begin
          if (req_ready_i) state_q <= S_DATA;
        end
        S_DATA: begin
          if (wready_i) begin
            if (last_beat) begin
              beat_q  <= '0;
              state_q <= S_RESP;
            end else begin
              beat_q <= beat_q + 5'd1;
            end
          end
        end
        S_RESP: begin
          if (resp_valid_i) begin
            if (resp_err_i) err_q <= 1'b1;
            addr_q <= addr_d;
            rem_q  <= rem_d;
            if (rem_d == 16'd0) begin
              state_q <= S_FIN;
            end else begin
              blen_q  <= burst_of(rem_d);
              state_q <= S_WAIT_DATA;
            end
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs decoded from state/counters; only the pop strobe looks at wready_i.
  always_comb begin
    busy_o      = (state_q != S_IDLE);
    done_o      = (state_q == S_FIN);
    err_o       = err_q;
    req_valid_o = (state_q == S_REQ);
    req_addr_o  = (state_q == S_REQ) ? addr_q : 32'd0;
    req_len_o   = (state_q == S_REQ) ? 4'(blen_q - 5'd1) : 4'd0;
    wvalid_o    = (state_q == S_DATA);
    wdata_o     = (state_q == S_DATA) ? fifo_data_i : '0;
    wlast_o     = (state_q == S_DATA) && last_beat;
    fifo_ren_o  = wvalid_o & wready_i;
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Randomized bench for fifo_burst_reader with a queue-based FIFO and a
// burst-list reference model derived from the transfer parameters.
module tb_fifo_burst_reader;

  localparam int DATA_BITS = 32;
  localparam int BURST_LEN = 4;
  localparam int CNT_BITS  = 5;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start_i;
  logic [31:0]          base_addr_i;
  logic [15:0]          total_beats_i;
  logic [CNT_BITS-1:0]  fifo_cnt_i;
  logic [DATA_BITS-1:0] fifo_data_i;
  logic                 fifo_ren_o;
  logic                 req_valid_o;
  logic                 req_ready_i;
  logic [31:0]          req_addr_o;
  logic [3:0]           req_len_o;
  logic                 wvalid_o;
  logic                 wready_i;
  logic [DATA_BITS-1:0] wdata_o;
  logic                 wlast_o;
  logic                 resp_valid_i;
  logic                 resp_err_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 err_o;

  fifo_burst_reader #(
    .DATA_BITS(DATA_BITS), .BURST_LEN(BURST_LEN), .CNT_BITS(CNT_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .base_addr_i(base_addr_i),
    .total_beats_i(total_beats_i), .fifo_cnt_i(fifo_cnt_i), .fifo_data_i(fifo_data_i),
    .fifo_ren_o(fifo_ren_o), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .req_addr_o(req_addr_o), .req_len_o(req_len_o), .wvalid_o(wvalid_o),
    .wready_i(wready_i), .wdata_o(wdata_o), .wlast_o(wlast_o),
    .resp_valid_i(resp_valid_i), .resp_err_i(resp_err_i), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks;
  int failures;

  logic [31:0] fq[$];        // FIFO contents, head at index 0
  logic [31:0] pushed[$];    // every word written for the current transfer
  logic [31:0] got_addr[$];
  int          got_len[$];
  logic [31:0] got_data[$];
  bit          got_last[$];
  int          npops;
  bit          g_err;        // expected err_o
  logic [31:0] junk;

  task automatic fifo_drive();
    fifo_cnt_i  = CNT_BITS'(fq.size());
    fifo_data_i = (fq.size() > 0) ? fq[0] : 32'hDEAD_BEEF;
  endtask

  task automatic fifo_push();
    logic [31:0] w;
    w = $urandom;
    fq.push_back(w);
    pushed.push_back(w);
  endtask

  // One complete transfer with model-derived expectations.
  // wr_mode: 0 always ready, 1 repeating 1,0,0,1, 2 random.
  // rr_mode: 0 always ready, 1 random. hold: cycles during which the FIFO
  // is capped at 3 words.
  task automatic run_xfer(input string tag, input logic [31:0] base, input int total,
                          input int wr_mode, input int rr_mode, input logic [15:0] err_mask,
                          input bit prefill, input int hold);
    logic [31:0] ea[$];
    int          el[$];
    bit          elast[$];
    bit          exp_fin_err, err_at_done, pop, pwv, pwr, prv, prr;
    logic [31:0] pwd, pra;
    logic [3:0]  prl;
    logic [3:0]  pat;
    int off, b, done_seen, after, resp_wait, burst_i;
    int err_bad, stall_bad, req_bad, ren_bad, hold_bad, dbad;

    // Reference: cut the transfer into min(BURST_LEN, remaining) pieces.
    off = 0; exp_fin_err = 1'b0;
    while (off < total) begin
      b = (total - off > BURST_LEN) ? BURST_LEN : total - off;
      ea.push_back(base + 32'(off * (DATA_BITS / 8)));
      el.push_back(b - 1);
      for (int k = 0; k < b; k++) elast.push_back(k == b - 1);
      if (err_mask[ea.size() - 1]) exp_fin_err = 1'b1;
      off += b;
    end

    fq.delete(); pushed.delete(); got_addr.delete(); got_len.delete();
    got_data.delete(); got_last.delete(); npops = 0;
    if (prefill) while (pushed.size() < total && fq.size() < 16) fifo_push();
    fifo_drive();

    pat = 4'b1001;
    done_seen = 0; after = 0; resp_wait = -1; burst_i = 0;
    err_bad = 0; stall_bad = 0; req_bad = 0; ren_bad = 0; hold_bad = 0; dbad = 0;
    pwv = 0; pwr = 0; prv = 0; prr = 0; pwd = '0; pra = '0; prl = '0; err_at_done = 0;

    @(posedge clk); #1;
    start_i = 1'b1; base_addr_i = base; total_beats_i = 16'(total);
    wready_i = 1'b1; req_ready_i = 1'b1; resp_valid_i = 1'b0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (err_o !== g_err) err_bad++;
      if (cyc < hold && req_valid_o === 1'b1) hold_bad++;
      if (pwv && !pwr && (wvalid_o !== 1'b1 || wdata_o !== pwd)) stall_bad++;
      if (prv && !prr && (req_valid_o !== 1'b1 || req_addr_o !== pra || req_len_o !== prl))
        stall_bad++;
      if (fifo_ren_o !== (wvalid_o & wready_i)) ren_bad++;
      pop = (fifo_ren_o === 1'b1);
      if (pop) npops++;
      if (req_valid_o && req_ready_i) begin
        got_addr.push_back(req_addr_o);
        got_len.push_back(int'(req_len_o));
        if (int'(fifo_cnt_i) < int'(req_len_o) + 1) req_bad++;
      end
      if (wvalid_o && wready_i) begin
        got_data.push_back(wdata_o);
        got_last.push_back(wlast_o);
        if (wlast_o) resp_wait = $urandom_range(0, 3);
      end
      if (done_o === 1'b1) begin done_seen++; err_at_done = err_o; end
      if (done_seen > 0) after++;
      pwv = wvalid_o; pwr = wready_i; pwd = wdata_o;
      prv = req_valid_o; prr = req_ready_i; pra = req_addr_o; prl = req_len_o;
      if (after >= 3) break;

      @(posedge clk);
      if (start_i) g_err = 1'b0;
      if (resp_valid_i && resp_err_i) g_err = 1'b1;
      if (pop && fq.size() > 0) junk = fq.pop_front();
      #1;
      start_i = 1'b0;
      if (pushed.size() < total && fq.size() < 16 && (prefill || $urandom_range(0, 2) == 0)
          && !(cyc < hold && pushed.size() >= 3))
        fifo_push();
      fifo_drive();
      case (wr_mode)
        0:       wready_i = 1'b1;
        1:       wready_i = pat[cyc % 4];
        default: wready_i = 1'($urandom_range(0, 1));
      endcase
      req_ready_i  = (rr_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      resp_valid_i = 1'b0;
      resp_err_i   = 1'($urandom_range(0, 1));
      if (resp_wait == 0) begin
        resp_valid_i = 1'b1;
        resp_err_i   = err_mask[burst_i];
        burst_i++;
        resp_wait = -1;
      end else if (resp_wait > 0) begin
        resp_wait--;
      end
    end

    checks++;
    if (done_seen != 1) begin
      failures++;
      $display("FAIL %s done_pulses got=%0d exp=1 (0 means timeout)", tag, done_seen);
    end
    checks++;
    if (got_addr.size() != ea.size()) begin
      failures++;
      $display("FAIL %s req_count got=%0d exp=%0d", tag, got_addr.size(), ea.size());
    end
    for (int i = 0; i < ea.size() && i < got_addr.size(); i++) begin
      checks++;
      if (got_addr[i] !== ea[i] || got_len[i] != el[i]) begin
        failures++;
        $display("FAIL %s req[%0d] got=(%h,%0d) exp=(%h,%0d)", tag, i, got_addr[i], got_len[i],
                 ea[i], el[i]);
      end
    end
    checks++;
    if (got_data.size() != total) begin
      failures++;
      $display("FAIL %s beat_count got=%0d exp=%0d", tag, got_data.size(), total);
    end
    for (int i = 0; i < total && i < got_data.size(); i++)
      if (got_data[i] !== pushed[i] || got_last[i] != elast[i]) dbad++;
    checks++;
    if (dbad != 0) begin
      failures++;
      $display("FAIL %s beat_data_last got=%0d bad_beats exp=0", tag, dbad);
    end
    checks++;
    if (npops != total) begin
      failures++;
      $display("FAIL %s pop_count got=%0d exp=%0d", tag, npops, total);
    end
    checks++;
    if (ren_bad + stall_bad + req_bad != 0) begin
      failures++;
      $display("FAIL %s handshake_rules got=ren%0d/stall%0d/reqfifo%0d exp=0/0/0", tag,
               ren_bad, stall_bad, req_bad);
    end
    checks++;
    if (err_bad != 0) begin
      failures++;
      $display("FAIL %s err_tracking got=%0d bad_cycles exp=0", tag, err_bad);
    end
    checks++;
    if (err_at_done !== exp_fin_err) begin
      failures++;
      $display("FAIL %s err_at_done got=%0b exp=%0b", tag, err_at_done, exp_fin_err);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL %s busy_after_done got=%0b exp=0", tag, busy_o);
    end
    if (hold > 0) begin
      checks++;
      if (hold_bad != 0) begin
        failures++;
        $display("FAIL %s req_while_fifo_short got=%0d cycles exp=0", tag, hold_bad);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 0; base_addr_i = 32'h1234_5678; total_beats_i = 16'd5;
    wready_i = 1; req_ready_i = 1; resp_valid_i = 0; resp_err_i = 0;
    fq.delete(); fq.push_back(32'hA5A5_A5A5); fifo_drive(); g_err = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy_o, done_o, err_o} !== 3'b000) begin
      failures++; $display("FAIL reset_status got=%b exp=000", {busy_o, done_o, err_o});
    end
    checks++;
    if ({req_valid_o, req_addr_o, req_len_o} !== '0) begin
      failures++; $display("FAIL reset_req got=%b/%h/%h exp=0", req_valid_o, req_addr_o, req_len_o);
    end
    checks++;
    if ({wvalid_o, wlast_o, wdata_o, fifo_ren_o} !== '0) begin
      failures++; $display("FAIL reset_wr got=%b/%b/%h/%b exp=0", wvalid_o, wlast_o, wdata_o, fifo_ren_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_xfer("basic8", 32'h1000, 8, 0, 0, 16'h0, 1'b1, 0);
    checks++;
    if (got_addr.size() < 2 || got_addr[1] !== 32'h1010 || got_len[1] != 3) begin
      failures++; $display("FAIL basic8_second_req got_n=%0d exp=(00001010,3)", got_addr.size());
    end
  endtask

  task automatic test_partial();
    run_xfer("partial6", 32'h1000, 6, 0, 0, 16'h0, 1'b1, 0);
    checks++;
    if (got_len.size() < 2 || got_len[1] != 1 || got_addr[1] !== 32'h1010) begin
      failures++; $display("FAIL partial6_tail_req got_n=%0d exp=(00001010,1)", got_len.size());
    end
  endtask

  task automatic test_fifo_wait();
    run_xfer("fifo_wait", 32'h0000_4000, 4, 0, 0, 16'h0, 1'b0, 30);
  endtask

  task automatic test_wready_pattern();
    run_xfer("wready_1001", 32'h0000_8000, 8, 1, 0, 16'h0, 1'b1, 0);
  endtask

  task automatic test_err_sticky();
    run_xfer("err_first", 32'h0000_1000, 8, 0, 0, 16'h0001, 1'b1, 0);
    run_xfer("err_clear", 32'h0000_2000, 8, 0, 0, 16'h0000, 1'b1, 0);
  endtask

  task automatic test_random();
    run_xfer("wrap", 32'hFFFF_FFF0, 12, 2, 1, 16'h0004, 1'b0, 0);
    for (int t = 0; t < 6; t++) begin
      run_xfer($sformatf("rand%0d", t), $urandom & 32'hFFFF_FFFC, $urandom_range(1, 20),
               $urandom_range(0, 2), $urandom_range(0, 1), 16'($urandom), 1'($urandom_range(0, 1)), 0);
    end
  endtask

  task automatic test_reset_mid();
    int nb, nreq, nren, ndone;
    bit pp;
    fq.delete(); pushed.delete();
    for (int i = 0; i < 8; i++) fifo_push();
    fifo_drive();
    @(posedge clk); #1;
    start_i = 1; base_addr_i = 32'h2000; total_beats_i = 16'd8;
    wready_i = 1; req_ready_i = 1; resp_valid_i = 0;
    nb = 0;
    for (int c = 0; c < 40 && nb < 2; c++) begin
      @(negedge clk);
      pp = (fifo_ren_o === 1'b1);
      if (pp) nb++;
      @(posedge clk);
      if (pp) junk = fq.pop_front();
      #1; start_i = 0; fifo_drive();
    end
    checks++;
    if (wvalid_o !== 1'b1 || nb != 2) begin
      failures++; $display("FAIL mid_burst_active got=wvalid%b beats%0d exp=1/2", wvalid_o, nb);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, err_o, req_valid_o, req_addr_o, req_len_o,
         wvalid_o, wlast_o, wdata_o, fifo_ren_o} !== '0) begin
      failures++;
      $display("FAIL async_reset_outputs got=busy%b wv%b wd%h ren%b exp=0", busy_o, wvalid_o,
               wdata_o, fifo_ren_o);
    end
    g_err = 0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    nreq = 0; nren = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_valid_o === 1'b1) nreq++;
      if (fifo_ren_o === 1'b1) nren++;
    end
    checks++;
    if (nreq + nren != 0) begin
      failures++; $display("FAIL post_reset_idle got=req%0d ren%0d exp=0/0", nreq, nren);
    end
    @(posedge clk); #1;
    start_i = 1; total_beats_i = 16'd0; base_addr_i = 32'h3000;
    @(posedge clk); #1;
    start_i = 0;
    ndone = 0; nreq = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done_o === 1'b1) ndone++;
      if (req_valid_o === 1'b1 || fifo_ren_o === 1'b1) nreq++;
    end
    checks++;
    if (ndone != 1 || nreq != 0) begin
      failures++; $display("FAIL zero_total got=done%0d req%0d exp=1/0", ndone, nreq);
    end
  endtask

  initial begin
    checks = 0; failures = 0;
    test_reset();
    test_basic();
    test_partial();
    test_fifo_wait();
    test_wready_pattern();
    test_err_sticky();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
